imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Sequences the 256-word instruction memory at power-up and on demand.
- Accepts a word stream over a valid/ready handshake and writes each word to consecutive word addresses through the memory write port.
- Verifies a trailing XOR checksum word, then releases the CPU (cpu_run) to fetch from address 0.
- Holds the CPU stalled during loading and after any load error.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words.
- CNT_W, 9, width of the length/count fields; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load.
- load_len  input  CNT_W  number of program words (checksum word excluded); sampled on start.
- in_valid  input  1  stream word valid.
- in_data  input  32  stream word.
- in_ready  output  1  loader can accept in_data this cycle.
- mem_we  output  1  instruction memory write enable.
- mem_waddr  output  32  byte address; always word-aligned (bits [1:0] = 0).
- mem_wdata  output  32  write data.
- cpu_run  output  1  1 = CPU may fetch/execute; 0 = CPU held.
- busy  output  1  high in LOAD or CHECK.
- done  output  1  high in RUN.
- error  output  1  high in ERR.
- err_code  output  2  0 none, 1 bad length, 2 checksum mismatch.
- loaded_words  output  CNT_W  program words accepted in the current or last load.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; internal len, count and csum cleared.
- States: IDLE, LOAD, CHECK, RUN, ERR.
- Handshake: a word is accepted when in_valid && in_ready on a rising edge. in_ready is a registered output: 1 exactly while in LOAD or CHECK.
- IDLE:
  - start with 1 <= load_len <= DEPTH: latch len, count=0, csum=0, go to LOAD.
  - start with load_len = 0 or > DEPTH: go to ERR, err_code=1.
- LOAD, on each accepted word:
  - Next cycle: mem_we=1, mem_waddr = count*4, mem_wdata = word. This is one-cycle registered write latency.
  - mem_we is 0 in every cycle with no write.
  - csum <= csum ^ word; count <= count+1; loaded_words tracks count.
  - When the accepted word is number len (count == len-1 before increment), go to CHECK.
- CHECK:
  - Next accepted word is the checksum; it is never written to memory.
  - Equal to csum: go to RUN. Otherwise go to ERR with err_code=2.
- RUN: cpu_run=1, done=1.
  - start with a legal length: cpu_run drops to 0 on the next cycle, state goes to LOAD with the same latching as from IDLE.
  - start with an illegal length: go to ERR, err_code=1.
- ERR: cpu_run=0, error=1; err_code held. start behaves as in IDLE, and a legal start clears error/err_code.
- start while busy: ignored.
- in_valid while not busy: ignored, no write.
- Stalls: in_valid may drop at any time; no timeout.
- Address wrap cannot occur: len <= DEPTH, so the highest address is (DEPTH-1)*4 = 0x3FC.
- Reset mid-load: returns to IDLE immediately with cpu_run=0 and mem_we=0. Memory contents are partial/undefined; software must reload.
- cpu_run is a registered output and never glitches. It changes only on the CHECK→RUN transition, on leaving RUN, or on reset.

Decomposition:
- Shared package imem_pkg:
  - state encoding localparams ST_IDLE..ST_ERR;
  - err_code constants ERR_NONE, ERR_LEN, ERR_CSUM;
  - IMEM_DEPTH = 256.
- No sub-module. A single FSM with a datapath of count, csum and the write register fits in one module.

Test Plan:
- Basic load: start, load_len=3; words 0x20080005, 0x20090003, 0x01095020, then checksum (XOR of the three). Required: three writes at 0x0, 0x4, 0x8 with matching data; cpu_run=1; done=1; loaded_words=3.
- Bad checksum: load_len=2; words 0x11111111, 0x22222222, then 0x00000000. Required: two writes; error=1; err_code=2; cpu_run=0; no third write.
- Illegal length: start with load_len=0, and separately load_len=257. Required: next cycle error=1, err_code=1, in_ready=0, no writes.
- Stalled stream plus start while busy: load_len=256 with in_valid toggled randomly and start pulsed mid-load. Required: start ignored; 256 writes with the last at 0x3FC; run on the correct checksum.
- Reset mid-load: assert rst_n=0 after 5 of 10 words. Required: all outputs 0 asynchronously; after release, IDLE with in_ready=0; a fresh load of 1 word succeeds.
- Reload from RUN: after a successful load, start with load_len=1. Required: cpu_run=0 on the next cycle; new write at 0x0; cpu_run=1 after the checksum.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants for the instruction memory boot loader
//
// Purpose: state encoding, error codes and default memory depth used by
//          imem_boot_loader. No ports (package).
package imem_pkg;

  localparam int IMEM_DEPTH = 256;

  // Loader FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  // err_code values
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

endpackage

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams a program into instruction memory and releases the CPU
//
// Purpose: accepts load_len words over a valid/ready stream, writes them to
//          consecutive word addresses, verifies a trailing XOR checksum word
//          and then raises cpu_run. The CPU stays held while loading and after
//          any error.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, load_len     begin a load of load_len program words
//   in_valid, in_data,
//   in_ready            word stream handshake
//   mem_we, mem_waddr,
//   mem_wdata           registered memory write port (byte address)
//   cpu_run             CPU release
//   busy, done, error,
//   err_code            status
//   loaded_words        program words accepted in the current or last load
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] load_len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_waddr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_run,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] loaded_words
);

  localparam logic [CNT_W-1:0] DEPTH_C = DEPTH[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] count;
  logic [31:0]      csum;
  logic             accept;
  logic             len_ok;

  assign accept = in_valid && in_ready;
  assign len_ok = (load_len != '0) && (load_len <= DEPTH_C);

  assign busy         = (state == ST_LOAD) || (state == ST_CHECK);
  assign done         = (state == ST_RUN);
  assign error        = (state == ST_ERR);
  assign loaded_words = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      len       <= '0;
      count     <= '0;
      csum      <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      // Write strobe is a single-cycle pulse following each accepted word
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (start) begin
            cpu_run <= 1'b0;
            if (len_ok) begin
              state    <= ST_LOAD;
              len      <= load_len;
              count    <= '0;
              csum     <= '0;
              in_ready <= 1'b1;
              err_code <= ERR_NONE;
            end else begin
              state    <= ST_ERR;
              in_ready <= 1'b0;
              err_code <= ERR_LEN;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_waddr <= {{(30-CNT_W){1'b0}}, count, 2'b00};
            mem_wdata <= in_data;
            csum      <= csum ^ in_data;
            count     <= count + ONE_C;
            // in_ready stays high: the checksum word follows immediately
            if (count == len - ONE_C) begin
              state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state   <= ST_RUN;
              cpu_run <= 1'b1;
            end else begin
              state    <= ST_ERR;
              err_code <= ERR_CSUM;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          cpu_run  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;
  import imem_pkg::*;

  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] load_len = '0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_ready;
  logic             mem_we;
  logic [31:0]      mem_waddr;
  logic [31:0]      mem_wdata;
  logic             cpu_run;
  logic             busy;
  logic             done;
  logic             error;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] loaded_words;

  int checks = 0;
  int failures = 0;
  int nwrites = 0;
  logic [31:0] last_addr;
  logic [31:0] model_csum;
  logic [63:0] exp_q[$];

  imem_boot_loader #(.DEPTH(256), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .loaded_words(loaded_words)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: every memory write must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      nwrites++;
      last_addr = mem_waddr;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {mem_waddr, mem_wdata}, 64'h0);
      end else begin
        check("write_addr_data", {mem_waddr, mem_wdata}, exp_q.pop_front());
      end
    end
  end

  task automatic do_start(input int len);
    @(negedge clk);
    start = 1'b1;
    load_len = len[CNT_W-1:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  // Send one word; expectation pushed when acceptance is certain. Returns just after the accepting edge.
  task automatic send(input logic [31:0] w, input bit prog, input logic [31:0] addr);
    int budget;
    budget = 50;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = w;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      check("handshake_timeout", 64'd0, 64'd1);
    end else if (prog) begin
      exp_q.push_back({addr, w});
      model_csum = model_csum ^ w;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] basic_words [3];
    int wr0;
    basic_words[0] = 32'h20080005;
    basic_words[1] = 32'h20090003;
    basic_words[2] = 32'h01095020;

    // Reset state
    #12;
    check("reset_outputs", {in_ready, mem_we, cpu_run, busy, done, error, err_code, loaded_words}, 64'd0);
    check("reset_waddr_wdata", {mem_waddr, mem_wdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic load of 3 words
    model_csum = '0;
    wr0 = nwrites;
    do_start(3);
    check("basic_in_ready", {in_ready, busy, cpu_run}, {61'd0, 3'b110});
    for (int i = 0; i < 3; i++) send(basic_words[i], 1'b1, 32'(i * 4));
    send(32'h20080005 ^ 32'h20090003 ^ 32'h01095020, 1'b0, 32'h0);
    check("basic_run", {cpu_run, done, busy, error, in_ready}, {59'd0, 5'b11000});
    check("basic_loaded_words", 64'(loaded_words), 64'd3);
    drain();
    check("basic_write_count", 64'(nwrites - wr0), 64'd3);

    // Bad checksum: started from RUN
    model_csum = '0;
    wr0 = nwrites;
    do_start(2);
    send(32'h11111111, 1'b1, 32'h0);
    send(32'h22222222, 1'b1, 32'h4);
    send(32'h00000000, 1'b0, 32'h0);
    check("badcsum_status", {error, err_code, cpu_run, done, in_ready}, {59'd0, 1'b1, ERR_CSUM, 2'b00, 1'b0});
    drain();
    check("badcsum_write_count", 64'(nwrites - wr0), 64'd2);

    // Illegal lengths; stray stream words must not be written
    wr0 = nwrites;
    do_start(0);
    check("len0_status", {error, err_code, in_ready, busy}, {59'd0, 1'b1, ERR_LEN, 2'b00});
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    do_start(257);
    check("len257_status", {error, err_code, in_ready, cpu_run}, {59'd0, 1'b1, ERR_LEN, 2'b00});
    drain();
    check("illegal_no_writes", 64'(nwrites - wr0), 64'd0);

    // Full 256-word load with random stalls and an ignored mid-load start
    model_csum = '0;
    wr0 = nwrites;
    do_start(256);
    check("full_clears_error", {error, err_code, busy}, {61'd0, 1'b0, ERR_NONE, 1'b1});
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      if (i == 100) begin
        start = 1'b1;
        load_len = 9'd5;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_ignored", {busy, loaded_words}, {54'd0, 1'b1, 9'd100});
      end
      send($urandom(), 1'b1, 32'(i * 4));
    end
    check("full_in_check", {busy, cpu_run, loaded_words}, {53'd0, 2'b10, 9'd256});
    send(model_csum, 1'b0, 32'h0);
    check("full_run", {cpu_run, done, error}, {61'd0, 3'b110});
    drain();
    check("full_write_count", 64'(nwrites - wr0), 64'd256);
    check("full_last_addr", 64'(last_addr), 64'h3FC);

    // Reset after 5 of 10 words
    model_csum = '0;
    do_start(10);
    for (int i = 0; i < 5; i++) send(32'hA5A50000 + 32'(i), 1'b1, 32'(i * 4));
    drain();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs", {in_ready, mem_we, cpu_run, busy, done, error, err_code, loaded_words}, 64'd0);
    check("midreset_waddr_wdata", {mem_waddr, mem_wdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_idle", {in_ready, busy, done, error}, 64'd0);
    model_csum = '0;
    do_start(1);
    send(32'hCAFEF00D, 1'b1, 32'h0);
    send(32'hCAFEF00D, 1'b0, 32'h0);
    check("fresh_load_run", {cpu_run, done, loaded_words}, {53'd0, 2'b11, 9'd1});
    drain();

    // Reload from RUN
    model_csum = '0;
    do_start(1);
    check("reload_cpu_held", {cpu_run, busy}, {62'd0, 2'b01});
    send(32'h0BADC0DE, 1'b1, 32'h0);
    check("reload_still_held", 64'(cpu_run), 64'd0);
    send(32'h0BADC0DE, 1'b0, 32'h0);
    check("reload_run", {cpu_run, done}, {62'd0, 2'b11});
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
